// File: rtl/rpn_pop_exec.sv
// rpn_pop_exec: pop/execute end of the two-level RPN operand stack.
// Accepts an operation, checks the stack has enough operands, issues a
// request/acknowledge transaction to the ALU and writes the result back
// as the new stack top.
//
// Optional feature: define RPN_TIMEOUT_EN to abort an ALU request that is
// not acknowledged within ALU_TIMEOUT ISSUE cycles (err = 2'b10).
//
// Handshakes:
//   op_valid/op_ready : request accepted on a rising edge where both are 1;
//                       op_valid while op_ready=0 is ignored (no queuing).
//   alu_req/alu_ack   : alu_req and alu_op/alu_a/alu_b are registered and
//                       held constant until alu_ack=1 is sampled in ISSUE;
//                       alu_ack in any other state is ignored.
module rpn_pop_exec #(
   parameter int WIDTH       = 8,
   parameter int ALU_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] stk_a,
   input  logic [WIDTH-1:0] stk_b,
   input  logic [1:0]       stk_depth,
   output logic             alu_req,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic             alu_ack,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags,
   output logic             wb_en,
   output logic             wb_pop,
   output logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             done,
   output logic [1:0]       err,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WB    = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_UFLOW = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;

   state_t state;
   logic   is_bin;      // latched: operation pops two operands

   // Operand-count check on the incoming request (depth 3 counts as 2).
   logic req_bin;
   logic depth_ok;

`ifdef RPN_TIMEOUT_EN
   localparam int CW_RAW = $clog2(ALU_TIMEOUT + 1);
   localparam int CW     = (CW_RAW > 4) ? CW_RAW : 4;
   localparam logic [CW-1:0] TMO_LAST = CW'(ALU_TIMEOUT - 1);
   logic [CW-1:0] tmo_cnt;
`else
   localparam int unused_alu_timeout = ALU_TIMEOUT;
`endif

   // Classify the request: binary ops are codes 000..100, unary 101..111.
   always_comb begin
      req_bin  = (op_code <= 3'b100);
      depth_ok = req_bin ? (stk_depth[1] == 1'b1) : (stk_depth != 2'b00);
   end

   assign state_dbg = state;

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         is_bin   <= 1'b0;
         op_ready <= 1'b0;
         alu_req  <= 1'b0;
         alu_op   <= 3'b000;
         alu_a    <= '0;
         alu_b    <= '0;
         wb_en    <= 1'b0;
         wb_pop   <= 1'b0;
         wb_data  <= '0;
         result   <= '0;
         flags    <= 4'b0000;
         done     <= 1'b0;
         err      <= ERR_OK;
`ifdef RPN_TIMEOUT_EN
         tmo_cnt  <= '0;
`endif
      end else begin
         wb_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               op_ready <= 1'b1;
               if (op_valid && op_ready) begin
                  op_ready <= 1'b0;
                  alu_op   <= op_code;
                  is_bin   <= req_bin;
                  if (depth_ok) begin
                     state   <= ST_ISSUE;
                     err     <= ERR_OK;
                     alu_req <= 1'b1;
                     alu_a   <= req_bin ? stk_a : stk_b;
                     alu_b   <= req_bin ? stk_b : '0;
`ifdef RPN_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end else begin
                     state <= ST_ERR;
                     done  <= 1'b1;
                     err   <= ERR_UFLOW;
                  end
               end
            end
            ST_ISSUE: begin
               if (alu_ack) begin
                  // An ack in the same cycle as the timeout limit still wins.
                  state   <= ST_WB;
                  alu_req <= 1'b0;
                  wb_en   <= 1'b1;
                  wb_pop  <= is_bin;
                  wb_data <= alu_result;
                  result  <= alu_result;
                  flags   <= alu_flags;
                  done    <= 1'b1;
                  err     <= ERR_OK;
               end
`ifdef RPN_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  state   <= ST_ERR;
                  alu_req <= 1'b0;
                  done    <= 1'b1;
                  err     <= ERR_TMO;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ST_WB: begin
               state    <= ST_IDLE;
               wb_pop   <= 1'b0;
               op_ready <= 1'b1;
            end
            ST_ERR: begin
               state    <= ST_IDLE;
               op_ready <= 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               op_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
